// File: rtl/mem_stage_ctrl_if.sv
// rtl/mem_stage_ctrl_if.sv - data-memory request/ready bus between the memory stage and its responder
interface mem_stage_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             bus_req;
  logic             bus_we;
  logic [WIDTH-1:0] bus_addr;
  logic [WIDTH-1:0] bus_wdata;
  logic             bus_ready;
  logic [WIDTH-1:0] bus_rdata;
  logic             bus_err;

  // controller side: issues requests, sees completion
  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    output bus_err,
    input  bus_ready,
    input  bus_rdata
  );

  // responder side: accepts requests, signals completion
  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    input  bus_err,
    output bus_ready,
    output bus_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - memory-stage controller: load/store sequencing, stall, timeout watchdog, MEM/WB register
module mem_stage_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCSrcM,
  input  logic             RegWriteM,
  input  logic             MemWriteM,
  input  logic             MemtoRegM,
  input  logic [3:0]       WA3M,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic             StallM,
  mem_stage_ctrl_if.master bus,
  output logic             PCSrcW,
  output logic             RegWriteW,
  output logic             MemtoRegW,
  output logic [3:0]       WA3W,
  output logic [WIDTH-1:0] ALUOutW,
  output logic [WIDTH-1:0] ReadDataW
);

  // Counter is one bit wider than needed to hold TIMEOUT-1 so it can never wrap.
  localparam int            CW       = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CW-1:0]    r_wait_cnt;

  logic             r_bus_req;
  logic             r_bus_we;
  logic [WIDTH-1:0] r_bus_addr;
  logic [WIDTH-1:0] r_bus_wdata;
  logic             r_bus_err;

  logic             r_pcsrc_w;
  logic             r_regwrite_w;
  logic             r_memtoreg_w;
  logic [3:0]       r_wa3_w;
  logic [WIDTH-1:0] r_aluout_w;
  logic [WIDTH-1:0] r_readdata_w;

  logic             w_mem_op;
  logic             w_busy;
  logic             w_timeout;
  logic             w_done;
  logic             w_issue;
  logic             w_wb_load;

  assign w_mem_op  = MemWriteM | MemtoRegM;
  assign w_busy    = (r_state == S_BUSY);
  // bus_req is always high in BUSY, so ready is only ever looked at while a request is out
  assign w_timeout = w_busy && !bus.bus_ready && (r_wait_cnt == LAST_CNT);
  assign w_done    = w_busy && (bus.bus_ready || w_timeout);

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_we    = r_bus_we;
  assign bus.bus_addr  = r_bus_addr;
  assign bus.bus_wdata = r_bus_wdata;
  assign bus.bus_err   = r_bus_err;

  assign PCSrcW    = r_pcsrc_w;
  assign RegWriteW = r_regwrite_w;
  assign MemtoRegW = r_memtoreg_w;
  assign WA3W      = r_wa3_w;
  assign ALUOutW   = r_aluout_w;
  assign ReadDataW = r_readdata_w;

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next state, stall and writeback-load decisions
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    w_wb_load    = 1'b0;
    StallM       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_op) begin
          StallM       = 1'b1;
          w_issue      = 1'b1;
          w_state_next = S_BUSY;
        end else begin
          w_wb_load    = 1'b1;
        end
      end
      S_BUSY: begin
        if (w_done) begin
          w_wb_load    = 1'b1;
          w_state_next = S_IDLE;
        end else begin
          StallM       = w_mem_op;
        end
      end
    endcase
  end

  // bus request launch/hold/drop, watchdog counter and timeout pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      r_bus_err   <= 1'b0;
      r_wait_cnt  <= '0;
    end else begin
      r_bus_err <= w_timeout;
      if (w_issue) begin
        r_bus_req   <= 1'b1;
        r_bus_we    <= MemWriteM;
        r_bus_addr  <= ALUResultM;
        r_bus_wdata <= WriteDataM;
        r_wait_cnt  <= '0;
      end else if (w_done) begin
        r_bus_req   <= 1'b0;
      end else if (w_busy) begin
        r_wait_cnt  <= r_wait_cnt + 1'b1;
      end
    end
  end

  // MEM/WB register: take the M fields when the instruction leaves, otherwise insert a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pcsrc_w    <= 1'b0;
      r_regwrite_w <= 1'b0;
      r_memtoreg_w <= 1'b0;
      r_wa3_w      <= '0;
      r_aluout_w   <= '0;
      r_readdata_w <= '0;
    end else if (w_wb_load) begin
      r_pcsrc_w    <= PCSrcM;
      r_regwrite_w <= RegWriteM;
      r_memtoreg_w <= MemtoRegM;
      r_wa3_w      <= WA3M;
      r_aluout_w   <= ALUResultM;
      // only a read that the responder actually answered returns data
      r_readdata_w <= (w_busy && bus.bus_ready && !r_bus_we) ? bus.bus_rdata : '0;
    end else begin
      r_pcsrc_w    <= 1'b0;
      r_regwrite_w <= 1'b0;
      r_memtoreg_w <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed table-driven bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

  logic        clk;
  logic        reset;
  logic        PCSrcM, RegWriteM, MemWriteM, MemtoRegM;
  logic [3:0]  WA3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM;
  logic        PCSrcW, RegWriteW, MemtoRegW;
  logic [3:0]  WA3W;
  logic [31:0] ALUOutW, ReadDataW;

  int total = 0;
  int bad   = 0;

  mem_stage_ctrl_if #(.WIDTH(32)) bus_if ();

  mem_stage_ctrl #(.WIDTH(32), .TIMEOUT(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .PCSrcM     (PCSrcM),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .MemtoRegM  (MemtoRegM),
    .WA3M       (WA3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .StallM     (StallM),
    .bus        (bus_if),
    .PCSrcW     (PCSrcW),
    .RegWriteW  (RegWriteW),
    .MemtoRegW  (MemtoRegW),
    .WA3W       (WA3W),
    .ALUOutW    (ALUOutW),
    .ReadDataW  (ReadDataW)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ic = {reset, PCSrcM, RegWriteM, MemWriteM, MemtoRegM, bus_ready}
  // oc = {StallM, bus_req, bus_we, bus_err, PCSrcW, RegWriteW, MemtoRegW}
  typedef struct {
    bit [5:0]  ic;
    bit [3:0]  wa3;
    bit [31:0] alu;
    bit [31:0] wd;
    bit [31:0] rdata;
    bit [6:0]  oc;
    bit [3:0]  wa3w;
    bit [31:0] addr;
    bit [31:0] wdata;
    bit [31:0] aluw;
    bit [31:0] rdw;
  } vec_t;

  localparam int NV = 26;
  vec_t vec [NV];

  function automatic vec_t mk(input bit [5:0] ic, input bit [3:0] wa3, input bit [31:0] alu,
                              input bit [31:0] wd, input bit [31:0] rdata, input bit [6:0] oc,
                              input bit [3:0] wa3w, input bit [31:0] addr, input bit [31:0] wdata,
                              input bit [31:0] aluw, input bit [31:0] rdw);
    vec_t v;
    v.ic = ic; v.wa3 = wa3; v.alu = alu; v.wd = wd; v.rdata = rdata;
    v.oc = oc; v.wa3w = wa3w; v.addr = addr; v.wdata = wdata; v.aluw = aluw; v.rdw = rdw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit [5:0] ic, input bit [3:0] wa3, input bit [31:0] alu,
                       input bit [31:0] wd, input bit [31:0] rdata);
    {reset, PCSrcM, RegWriteM, MemWriteM, MemtoRegM, bus_if.bus_ready} = ic;
    WA3M             = wa3;
    ALUResultM       = alu;
    WriteDataM       = wd;
    bus_if.bus_rdata = rdata;
  endtask

  function automatic logic [159:0] outs_now();
    return {StallM, bus_if.bus_req, bus_if.bus_we, bus_if.bus_err, PCSrcW, RegWriteW, MemtoRegW,
            WA3W, bus_if.bus_addr, bus_if.bus_wdata, ALUOutW, ReadDataW};
  endfunction

  function automatic logic [159:0] outs_exp(input vec_t v, input logic stall_now);
    return {stall_now, v.oc[5:0], v.wa3w, v.addr, v.wdata, v.aluw, v.rdw};
  endfunction

  initial begin
    #100000;
    $display("FAIL global_time_limit got=expired want=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int  stalls;
    int  errs;
    bit  done;

    drive(6'b100000, 4'd0, 32'h0, 32'h0, 32'h0);

    vec[0]  = mk(6'b100000,  0, 'h0,    'h0,    'h0,        7'b0000000,  0, 'h0,   'h0,    'h0,    'h0);
    vec[1]  = mk(6'b001000,  5, 'h1234, 'h0,    'h0,        7'b0000010,  5, 'h0,   'h0,    'h1234, 'h0);
    vec[2]  = mk(6'b011000,  6, 'h5678, 'h0,    'h0,        7'b0000110,  6, 'h0,   'h0,    'h5678, 'h0);
    vec[3]  = mk(6'b000000,  7, 'h9abc, 'h0,    'h0,        7'b0000000,  7, 'h0,   'h0,    'h9abc, 'h0);
    for (int i = 4; i <= 6; i++)
      vec[i] = mk(6'b001010, 3, 'h100,  'h55,   'h0,        7'b1100000,  7, 'h100, 'h55,   'h9abc, 'h0);
    vec[7]  = mk(6'b001011,  3, 'h100,  'h55,   'hdeadbeef, 7'b0000011,  3, 'h100, 'h55,   'h100,  'hdeadbeef);
    vec[8]  = mk(6'b000100,  9, 'h20,   'hcafe, 'h0,        7'b1110000,  3, 'h20,  'hcafe, 'h100,  'hdeadbeef);
    vec[9]  = mk(6'b000101,  9, 'h20,   'hcafe, 'h1111,     7'b0010000,  9, 'h20,  'hcafe, 'h20,   'h0);
    vec[10] = mk(6'b001010, 10, 'h200,  'h0,    'h0,        7'b1100000,  9, 'h200, 'h0,    'h20,   'h0);
    vec[11] = mk(6'b001011, 10, 'h200,  'h0,    'ha1,       7'b0000011, 10, 'h200, 'h0,    'h200,  'ha1);
    vec[12] = mk(6'b001011, 11, 'h204,  'h0,    'hff,       7'b1100000, 10, 'h204, 'h0,    'h200,  'ha1);
    vec[13] = mk(6'b001011, 11, 'h204,  'h0,    'hb2,       7'b0000011, 11, 'h204, 'h0,    'h204,  'hb2);
    for (int i = 14; i <= 17; i++)
      vec[i] = mk(6'b001010, 12, 'h300, 'h0,    'h0,        7'b1100000, 11, 'h300, 'h0,    'h204,  'hb2);
    vec[18] = mk(6'b001010, 12, 'h300,  'h0,    'h0,        7'b0001011, 12, 'h300, 'h0,    'h300,  'h0);
    vec[19] = mk(6'b001000, 13, 'h77,   'h0,    'h0,        7'b0000010, 13, 'h300, 'h0,    'h77,   'h0);
    vec[20] = mk(6'b001010, 14, 'h400,  'h0,    'h0,        7'b1100000, 13, 'h400, 'h0,    'h77,   'h0);
    vec[21] = mk(6'b001010, 14, 'h400,  'h0,    'h0,        7'b1100000, 13, 'h400, 'h0,    'h77,   'h0);
    vec[22] = mk(6'b101010, 14, 'h400,  'h0,    'h0,        7'b1000000,  0, 'h0,   'h0,    'h0,    'h0);
    vec[23] = mk(6'b001010, 14, 'h400,  'h0,    'h0,        7'b1100000,  0, 'h400, 'h0,    'h0,    'h0);
    vec[24] = mk(6'b001011, 14, 'h400,  'h0,    'h4444,     7'b0000011, 14, 'h400, 'h0,    'h400,  'h4444);
    vec[25] = mk(6'b000000,  0, 'h0,    'h0,    'h0,        7'b0000000,  0, 'h400, 'h0,    'h0,    'h0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vec[i].ic, vec[i].wa3, vec[i].alu, vec[i].wd, vec[i].rdata);
      #1;
      chk($sformatf("v%0d_stall", i), {159'd0, StallM}, {159'd0, vec[i].oc[6]});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_outs", i), {1'b0, outs_now()}, {1'b0, outs_exp(vec[i], StallM)});
    end

    // ready arriving on the last BUSY cycle before the watchdog fires wins: data, no error
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      drive({5'b00101, (c == 4)}, 4'd15, 32'h500, 32'h0, (c == 4) ? 32'h5555 : 32'h0);
      #1;
      chk($sformatf("late_rdy_stall%0d", c), {159'd0, StallM}, {159'd0, (c != 4)});
      @(posedge clk);
      #1;
      chk($sformatf("late_rdy_err%0d", c), {159'd0, bus_if.bus_err}, 160'd0);
    end
    chk("late_rdy_data", {128'd0, ReadDataW}, {128'd0, 32'h5555});
    chk("late_rdy_wb", {152'd0, bus_if.bus_req, RegWriteW, MemtoRegW, 1'b0, WA3W},
                       {152'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15});

    // store that never gets ready: bounded count of stall cycles and error pulses
    @(negedge clk);
    drive(6'b000100, 4'd1, 32'h600, 32'hab, 32'h0);
    stalls = 0;
    errs   = 0;
    done   = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (!StallM) done = 1'b1;
      else stalls++;
      @(posedge clk);
      #1;
      if (bus_if.bus_err) errs++;
    end
    chk("timeout_bound", {159'd0, done}, {159'd0, 1'b1});
    chk("timeout_stalls", {128'd0, stalls}, {128'd0, 32'd4});
    chk("timeout_err_pulses", {128'd0, errs}, {128'd0, 32'd1});
    chk("timeout_wb", {64'd0, bus_if.bus_req, RegWriteW, MemtoRegW, bus_if.bus_we, ALUOutW, ReadDataW},
                      {64'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h600, 32'h0});

    // pipeline resumes with a plain ALU op, and the error pulse has ended
    @(negedge clk);
    drive(6'b001000, 4'd2, 32'h99, 32'h0, 32'h0);
    #1;
    chk("resume_stall", {159'd0, StallM}, 160'd0);
    @(posedge clk);
    #1;
    chk("resume_wb", {120'd0, bus_if.bus_err, RegWriteW, WA3W, ALUOutW},
                     {120'd0, 1'b0, 1'b1, 4'd2, 32'h99});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the pipelined processor: consumes the EX/MEM pipeline register outputs, runs data-memory loads and stores over a request/ready bus, and drives the MEM/WB pipeline register. It stalls the upstream pipeline while an access is outstanding. It bounds every access with a timeout watchdog. Non-memory instructions pass through to writeback in one cycle.

## Interface
- WIDTH, 32, data/address width
- TIMEOUT, 16, max cycles in BUSY before forced completion (≥1)

- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- PCSrcM, RegWriteM, MemWriteM, MemtoRegM  in  1 each  control bits from EX/MEM register
- WA3M  in  4  destination register
- ALUResultM  in  WIDTH  memory address / ALU result
- WriteDataM  in  WIDTH  store data
- StallM  out  1  hold EX/MEM and earlier stages (combinational)
- bus_req  out  1  access request (registered)
- bus_we  out  1  1 = write, 0 = read
- bus_addr  out  WIDTH  access address
- bus_wdata  out  WIDTH  store data
- bus_ready  in  1  responder completes access this cycle
- bus_rdata  in  WIDTH  load data, valid when bus_ready=1
- PCSrcW, RegWriteW, MemtoRegW  out  1 each  MEM/WB control
- WA3W  out  4  MEM/WB destination register
- ALUOutW  out  WIDTH  MEM/WB ALU result
- ReadDataW  out  WIDTH  MEM/WB load data
- bus_err  out  1  one-cycle pulse: access ended by timeout

## Operation
- mem_op = MemWriteM | MemtoRegM. MemWriteM=1 → write, including when both bits are set. Otherwise MemtoRegM=1 → read.
- FSM states IDLE, BUSY. Reset → IDLE.
- IDLE, mem_op=0: instruction is not stalled. WB register loads PCSrcM, RegWriteM, MemtoRegM, WA3M, ALUResultM, with ReadDataW=0.
- IDLE, mem_op=1:
  - StallM=1.
  - Next edge: bus_req←1, bus_we←MemWriteM, bus_addr←ALUResultM, bus_wdata←WriteDataM, wait_cnt←0, state←BUSY.
  - WB register loads a bubble: PCSrcW=RegWriteW=MemtoRegW=0, other fields unchanged.
- BUSY: bus_req, bus_we, bus_addr and bus_wdata are held stable until completion.
- Completion occurs when bus_ready=1, or when bus_ready=0 and wait_cnt==TIMEOUT-1 (timeout).
  - In the completion cycle, StallM=0 so upstream advances at the same edge.
  - At that edge: bus_req←0, state←IDLE, and WB loads the M fields.
  - ReadDataW←bus_rdata for a ready read; ReadDataW←0 for a write or a timeout.
  - bus_err←1 on timeout only, 0 on every other cycle.
- BUSY without completion: StallM=1, wait_cnt+1, WB loads a bubble.
- bus_ready is ignored while bus_req=0.
- StallM = mem_op & ~(state==BUSY & (bus_ready | timeout)). The same instruction is never issued twice.
- wait_cnt width is clog2(TIMEOUT)+1 and it never wraps.

## Timing
- Reset values: every output is 0, state=IDLE, wait_cnt=0.
- Reset in BUSY: bus_req drops at that edge, no WB update, and no bus_err.
- Non-memory instruction: 1 cycle in M, WB valid the following cycle.
- Memory access: the minimum is 2 cycles in M (1 stall cycle), when bus_ready=1 in the first BUSY cycle. A ready on the Nth BUSY cycle gives N+1 cycles in M.
- Timeout: exactly TIMEOUT BUSY cycles, so TIMEOUT+1 cycles in M.
- Back-to-back memory ops: after a completion the FSM is in IDLE with the new op present, so it issues the next edge. bus_req is low for exactly 1 cycle between accesses.
- Upstream must hold all M inputs constant while StallM=1.

## Test plan
- ALU op, RegWriteM=1, WA3M=5, ALUResultM=0x1234, stream of 3 ops → WB mirrors each one cycle later, StallM never 1, bus_req never 1.
- Load from addr 0x100, bus_ready after 3 BUSY cycles with rdata 0xDEADBEEF:
  - StallM=1 for 3 cycles.
  - bus_addr=0x100 and bus_we=0 stable throughout.
  - Then ReadDataW=0xDEADBEEF, MemtoRegW=1.
  - Exactly one non-bubble WB entry.
- Store 0xCAFE to 0x20, bus_ready on the first BUSY cycle → bus_we=1, bus_wdata=0xCAFE, 1 stall cycle, RegWriteW=0.
- Two consecutive loads, ready immediate:
  - bus_req pattern 1,0,1.
  - Two WB entries carrying the correct rdata and WA3 values.
- TIMEOUT=4 with bus_ready held 0:
  - 4 BUSY cycles.
  - bus_err pulses once.
  - ReadDataW=0.
  - Pipeline resumes.
- reset asserted in the second BUSY cycle → next cycle bus_req=0, all outputs 0, IDLE. A later load completes normally.
